// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM (async read, sync write).
// Optional wait states in the access phase are enabled with `define MEM_WAIT_EN.
module ram_arbiter #(
    parameter int DEPTH       = 9,
    parameter int WIDTH       = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [DEPTH-1:0] addr0,
    input  logic [DEPTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic             ram_wr_en,
    output logic [DEPTH-1:0] ram_r_addr,
    output logic [DEPTH-1:0] ram_w_addr,
    output logic [WIDTH-1:0] ram_w_data,
    input  logic [WIDTH-1:0] ram_r_data,
    output logic             busy,
    output logic             owner,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_owner;
    logic             r_rr_ptr;
    logic             r_we_q;
    logic             r_ack0;
    logic             r_ack1;
    logic [DEPTH-1:0] r_addr_q;
    logic [WIDTH-1:0] r_wdata_q;
    logic [WIDTH-1:0] r_rdata0;
    logic [WIDTH-1:0] r_rdata1;
    logic             w_grant;
    logic             w_grant_port;
    logic             w_last;
    logic             w_finish;

    // With both ports requesting, the round-robin pointer picks; otherwise the lone requester wins.
    assign w_grant      = (r_state == S_IDLE) && (req0 || req1);
    assign w_grant_port = (req0 && req1) ? r_rr_ptr : req1;

`ifdef MEM_WAIT_EN
    logic [3:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt <= 4'd0;
        end else if (w_grant) begin
            r_wait_cnt <= 4'(WAIT_CYCLES);
        end else if ((r_state == S_ACCESS) && (r_wait_cnt != 4'd0)) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end
    end

    assign w_last = (r_wait_cnt == 4'd0);
`else
    assign w_last = 1'b1;
`endif

    assign w_finish = (r_state == S_ACCESS) && w_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (req0 || req1) w_state_nxt = S_ACCESS;
            S_ACCESS: if (w_last) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner   <= 1'b0;
            r_rr_ptr  <= 1'b0;
            r_we_q    <= 1'b0;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            if (w_grant) begin
                r_owner   <= w_grant_port;
                r_we_q    <= w_grant_port ? we1 : we0;
                r_addr_q  <= w_grant_port ? addr1 : addr0;
                r_wdata_q <= w_grant_port ? wdata1 : wdata0;
            end
            // Ack is set on the closing edge of ACCESS, so it is high only during DONE.
            r_ack0 <= w_finish && !r_owner;
            r_ack1 <= w_finish && r_owner;
            if (w_finish) begin
                r_rr_ptr <= ~r_owner;
                if (!r_we_q) begin
                    if (r_owner) r_rdata1 <= ram_r_data;
                    else         r_rdata0 <= ram_r_data;
                end
            end
        end
    end

    // rst_n gating keeps a write from committing on the edge where reset is sampled.
    assign ram_wr_en   = w_finish && r_we_q && rst_n;
    assign ram_r_addr  = r_addr_q;
    assign ram_w_addr  = r_addr_q;
    assign ram_w_data  = r_wdata_q;
    assign ack0        = r_ack0;
    assign ack1        = r_ack1;
    assign rdata0      = r_rdata0;
    assign rdata1      = r_rdata1;
    assign busy        = (r_state != S_IDLE);
    assign owner       = r_owner;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: behavioural RAM, driver task, expected-read queue,
// ack exclusivity and write-pulse monitors, single summary line.
module tb_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [8:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic        ram_wr_en;
    logic [8:0]  ram_r_addr, ram_w_addr;
    logic [31:0] ram_w_data, ram_r_data;
    logic        busy, owner;
    logic [1:0]  o_dbg_state;

`ifdef MEM_WAIT_EN
    localparam int EXP_LAT = 2 + 2;
`else
    localparam int EXP_LAT = 2;
`endif

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;

    logic [31:0] mem     [512];
    logic [31:0] exp_mem [512];
    logic [31:0] exp_rd  [2];
    logic [31:0] exp_q[$];

    ram_arbiter #(.DEPTH(9), .WIDTH(32), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .ram_wr_en(ram_wr_en), .ram_r_addr(ram_r_addr), .ram_w_addr(ram_w_addr),
        .ram_w_data(ram_w_data), .ram_r_data(ram_r_data),
        .busy(busy), .owner(owner), .o_dbg_state(o_dbg_state)
    );

    // clock / reset-free behavioural RAM
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] preload(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    initial begin
        for (int i = 0; i < 512; i++) mem[i] <= preload(i);
    end

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_w_addr] <= ram_w_data;
    end
    assign ram_r_data = mem[ram_r_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // monitors
    always @(posedge clk) begin
        if (ram_wr_en) wr_cnt++;
    end

    always @(negedge clk) begin
        check("ack_exclusive", 32'(ack0 & ack1), 32'd0);
    end

    task automatic check_rdata(input string tag);
        check({tag, "_rdata0"}, rdata0, exp_rd[0]);
        check({tag, "_rdata1"}, rdata1, exp_rd[1]);
    endtask

    task automatic do_access(input int port, input logic we, input logic [8:0] addr,
                             input logic [31:0] data, input string tag);
        int          lat;
        bit          got;
        int          wr_before;
        logic [31:0] exp;
        @(negedge clk);
        wr_before = wr_cnt;
        if (port == 0) begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = data;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = data;
        end
        if (!we) exp_q.push_back(exp_mem[addr]);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            got = (port == 0) ? ack0 : ack1;
            if (!got) begin
                // post-grant changes must not disturb the access in flight
                if (port == 0) begin
                    we0 = ~we; addr0 = 9'($urandom_range(0, 511)); wdata0 = $urandom;
                end else begin
                    we1 = ~we; addr1 = 9'($urandom_range(0, 511)); wdata1 = $urandom;
                end
            end
        end
        if (port == 0) req0 = 1'b0;
        else           req1 = 1'b0;
        check({tag, "_ack_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, lat, EXP_LAT);
        check({tag, "_owner"}, 32'(owner), 32'(port));
        check({tag, "_wr_pulses"}, wr_cnt - wr_before, we ? 32'd1 : 32'd0);
        if (we) begin
            exp_mem[addr] = data;
        end else begin
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            else                  exp = 'x;
            exp_rd[port] = exp;
        end
        check_rdata(tag);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int cyc;
        int wr_before;
        logic [31:0] exp;

        for (int i = 0; i < 512; i++) exp_mem[i] = preload(i);
        exp_rd[0] = '0;
        exp_rd[1] = '0;

        // reset held 3 cycles with a write request pending on port 0
        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 9'h012; wdata0 = 32'hCAFE_F00D;
        req1 = 1'b0; we1 = 1'b0; addr1 = 9'h000; wdata1 = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_ack1", 32'(ack1), 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        check("rst_wr_en", 32'(ram_wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(o_dbg_state), 32'd0);
        check("rst_wr_cnt", wr_cnt, 32'd0);
        req0 = 1'b0;
        rst_n = 1'b1;

        // port 0 write then read back
        do_access(0, 1'b1, 9'h012, 32'hDEAD_BEEF, "p0_wr");
        do_access(0, 1'b0, 9'h012, 32'h0, "p0_rd");
        check("p0_rd_value", rdata0, 32'hDEAD_BEEF);

        // port 1 write at top address, port 0 read, then port 1 reads preload
        do_access(1, 1'b1, 9'h1FF, 32'h0000_0055, "p1_wr");
        do_access(0, 1'b0, 9'h1FF, 32'h0, "p0_rd_top");
        check("p0_rd_top_value", rdata0, 32'h0000_0055);
        do_access(1, 1'b0, 9'h033, 32'h0, "p1_rd");
        check("p1_rd_value", rdata1, 32'hA500_0033);

        // reset sampled during ACCESS of a write: no commit
        @(negedge clk);
        wr_before = wr_cnt;
        req0 = 1'b1; we0 = 1'b1; addr0 = 9'h020; wdata0 = 32'h1234_5678;
        @(negedge clk);
        check("abort_in_access", 32'(o_dbg_state), 32'd1);
        rst_n = 1'b0;
        req0 = 1'b0;
        #1;
        check("abort_wr_en", 32'(ram_wr_en), 32'd0);
        @(negedge clk);
        check("abort_state", 32'(o_dbg_state), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ack0", 32'(ack0), 32'd0);
        check("abort_no_write", wr_cnt - wr_before, 32'd0);
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        rst_n = 1'b1;
        do_access(0, 1'b0, 9'h020, 32'h0, "abort_rd");
        check("abort_rd_value", rdata0, 32'hA500_0020);

        // both ports requesting from reset: strict alternation 0,1,0,1
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 9'h001; wdata0 = 32'h0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 9'h002; wdata1 = 32'h0;
        repeat (3) @(negedge clk);
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(exp_mem[1]);
            exp_q.push_back(exp_mem[2]);
        end
        rst_n = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (ack0 || ack1) begin
                check("alt_grant_port", 32'(ack1), 32'(n % 2));
                check("alt_owner", 32'(owner), 32'(n % 2));
                if (exp_q.size() > 0) exp = exp_q.pop_front();
                else                  exp = 'x;
                check("alt_rdata", ack1 ? rdata1 : rdata0, exp);
                n++;
                if (n == 4) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
        end
        check("alt_all_acks", n, 32'd4);
        repeat (3) @(negedge clk);
        check("alt_end_idle", 32'(o_dbg_state), 32'd0);
        check("alt_end_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
